color_blob_tracker: RTL and testbench

- Downstream stage of the colour-highlight detector in the D8M camera video path.
- Treats every non-grey pixel (R, G, B not all equal) as a highlighted hit.
- Accumulates the bounding box and hit count of hits over each frame.
- Commits the result at frame end and overlays the committed box outline on the following frame before the VGA output.

---
 rtl/color_blob_tracker.sv | 193 +++++++++++++++++++
 tb/tb_color_blob_tracker.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/color_blob_tracker.sv
// Colour-blob tracker: bounding box and hit count of non-grey pixels per frame,
// committed at frame end and drawn as an outline on the following frame.
module color_blob_tracker #(
  parameter int          H_BITS     = 11,
  parameter int          V_BITS     = 10,
  parameter int          CNT_BITS   = 20,
  parameter int          MIN_PIXELS = 64,
  parameter logic [7:0]  BOX_R      = 8'd255,
  parameter logic [7:0]  BOX_G      = 8'd255,
  parameter logic [7:0]  BOX_B      = 8'd0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          in_r,
  input  logic [7:0]          in_g,
  input  logic [7:0]          in_b,
  input  logic                in_hs,
  input  logic                in_vs,
  input  logic                in_de,
  input  logic [1:0]          ctrl_in,
  input  logic                ovl_en,
  output logic [7:0]          out_r,
  output logic [7:0]          out_g,
  output logic [7:0]          out_b,
  output logic                out_hs,
  output logic                out_vs,
  output logic                out_de,
  output logic                box_valid,
  output logic [H_BITS-1:0]   box_xmin,
  output logic [H_BITS-1:0]   box_xmax,
  output logic [V_BITS-1:0]   box_ymin,
  output logic [V_BITS-1:0]   box_ymax,
  output logic [CNT_BITS-1:0] hit_count
);

  localparam logic [CNT_BITS-1:0] MIN_CNT = CNT_BITS'(MIN_PIXELS);

  function automatic logic [H_BITS-1:0] sat_inc_h(input logic [H_BITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [V_BITS-1:0] sat_inc_v(input logic [V_BITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_BITS-1:0] sat_inc_c(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic               de_d, vs_d;
  logic               de_rise, de_fall, vs_rise;
  logic [H_BITS-1:0]  x_cnt, x_pix;
  logic [V_BITS-1:0]  y_cnt;
  logic               frame_track, armed;
  logic               hit_s0;

  assign de_rise = in_de & ~de_d;
  assign de_fall = ~in_de & de_d;
  assign vs_rise = in_vs & ~vs_d;
  assign x_pix   = de_rise ? '0 : x_cnt;
  assign hit_s0  = in_de & frame_track & ~((in_r == in_g) && (in_g == in_b));

  // Stage 0: raster position and per-frame tracking mode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      de_d        <= 1'b0;
      vs_d        <= 1'b0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      frame_track <= 1'b0;
    end else begin
      de_d <= in_de;
      vs_d <= in_vs;
      if (in_de)
        x_cnt <= sat_inc_h(x_pix);
      if (vs_rise)
        y_cnt <= '0;
      else if (de_fall)
        y_cnt <= sat_inc_v(y_cnt);
      if (vs_rise)
        frame_track <= (ctrl_in != 2'b11);
    end
  end

  logic [7:0]        r_p1, g_p1, b_p1;
  logic              hs_p1, vs_p1, de_p1, hit_p1, ovl_p1;
  logic [H_BITS-1:0] x_p1;
  logic [V_BITS-1:0] y_p1;

  // Stage 1: registered pixel, position, hit flag and overlay switch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p1   <= '0;
      g_p1   <= '0;
      b_p1   <= '0;
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
      de_p1  <= 1'b0;
      hit_p1 <= 1'b0;
      ovl_p1 <= 1'b0;
      x_p1   <= '0;
      y_p1   <= '0;
    end else begin
      r_p1   <= in_r;
      g_p1   <= in_g;
      b_p1   <= in_b;
      hs_p1  <= in_hs;
      vs_p1  <= in_vs;
      de_p1  <= in_de;
      hit_p1 <= hit_s0;
      ovl_p1 <= ovl_en;
      x_p1   <= x_pix;
      y_p1   <= y_cnt;
    end
  end

  logic [H_BITS-1:0]   xmin_acc, xmax_acc;
  logic [V_BITS-1:0]   ymin_acc, ymax_acc;
  logic [CNT_BITS-1:0] cnt_acc;
  logic                commit_ok;

  // frame_track here is still the mode of the frame that is closing
  assign commit_ok = (cnt_acc >= MIN_CNT) & frame_track;

  // Accumulate stage-1 hits; a hit landing on the commit cycle is dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xmin_acc  <= '1;
      xmax_acc  <= '0;
      ymin_acc  <= '1;
      ymax_acc  <= '0;
      cnt_acc   <= '0;
      armed     <= 1'b0;
      box_valid <= 1'b0;
      box_xmin  <= '0;
      box_xmax  <= '0;
      box_ymin  <= '0;
      box_ymax  <= '0;
      hit_count <= '0;
    end else if (vs_rise) begin
      if (armed) begin
        hit_count <= cnt_acc;
        box_valid <= commit_ok;
        if (commit_ok) begin
          box_xmin <= xmin_acc;
          box_xmax <= xmax_acc;
          box_ymin <= ymin_acc;
          box_ymax <= ymax_acc;
        end
      end
      armed    <= 1'b1;
      xmin_acc <= '1;
      xmax_acc <= '0;
      ymin_acc <= '1;
      ymax_acc <= '0;
      cnt_acc  <= '0;
    end else if (hit_p1) begin
      if (x_p1 < xmin_acc) xmin_acc <= x_p1;
      if (x_p1 > xmax_acc) xmax_acc <= x_p1;
      if (y_p1 < ymin_acc) ymin_acc <= y_p1;
      if (y_p1 > ymax_acc) ymax_acc <= y_p1;
      cnt_acc <= sat_inc_c(cnt_acc);
    end
  end

  logic on_col, on_row, paint;

  assign on_col = ((x_p1 == box_xmin) | (x_p1 == box_xmax)) &
                  (y_p1 >= box_ymin) & (y_p1 <= box_ymax);
  assign on_row = ((y_p1 == box_ymin) | (y_p1 == box_ymax)) &
                  (x_p1 >= box_xmin) & (x_p1 <= box_xmax);
  assign paint  = ovl_p1 & box_valid & de_p1 & (on_col | on_row);

  // Stage 2: outline overlay and video output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_r  <= '0;
      out_g  <= '0;
      out_b  <= '0;
      out_hs <= 1'b0;
      out_vs <= 1'b0;
      out_de <= 1'b0;
    end else begin
      out_r  <= paint ? BOX_R : r_p1;
      out_g  <= paint ? BOX_G : g_p1;
      out_b  <= paint ? BOX_B : b_p1;
      out_hs <= hs_p1;
      out_vs <= vs_p1;
      out_de <= de_p1;
    end
  end

endmodule

// File: tb/tb_color_blob_tracker.sv
// Bench for color_blob_tracker: frame table with commit expectations, plus a
// per-pixel scoreboard of the 2-cycle video path including the outline overlay.
module tb_color_blob_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_r, in_g, in_b;
  logic        in_hs, in_vs, in_de;
  logic [1:0]  ctrl_in;
  logic        ovl_en;
  logic [7:0]  out_r, out_g, out_b;
  logic        out_hs, out_vs, out_de;
  logic        box_valid;
  logic [10:0] box_xmin, box_xmax;
  logic [9:0]  box_ymin, box_ymax;
  logic [19:0] hit_count;

  always #5 clk = ~clk;

  color_blob_tracker dut (
    .clk(clk), .rst(rst),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de),
    .ctrl_in(ctrl_in), .ovl_en(ovl_en),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_hs(out_hs), .out_vs(out_vs), .out_de(out_de),
    .box_valid(box_valid),
    .box_xmin(box_xmin), .box_xmax(box_xmax),
    .box_ymin(box_ymin), .box_ymax(box_ymax),
    .hit_count(hit_count)
  );

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       de;
  } vid_t;

  // One frame: size, optional square block (bs=0 means none), ctrl/ovl during
  // the frame, and the commit expected right after its closing vsync.
  typedef struct {
    int w, h, bx, by, bs, br, bg, bb, ctrl, ovl;
    int e_valid, e_cnt, e_xmin, e_xmax, e_ymin, e_ymax, e_yel;
  } row_t;

  vid_t q[$];
  row_t tbl[10];
  int   checks = 0;
  int   errors = 0;
  int   yel = 0;
  int   m_valid = 0, m_xmin = 0, m_xmax = 0, m_ymin = 0, m_ymax = 0;

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic check_video();
    vid_t e, a;
    a = {out_r, out_g, out_b, out_hs, out_vs, out_de};
    if (q.size() >= 2) begin
      e = q.pop_front();
      chk("video", longint'(a), longint'(e));
    end
    if (out_de && out_r == 8'hFF && out_g == 8'hFF && out_b == 8'h00)
      yel++;
  endtask

  function automatic bit perim(input int x, input int y);
    return ((x == m_xmin || x == m_xmax) && y >= m_ymin && y <= m_ymax) ||
           ((y == m_ymin || y == m_ymax) && x >= m_xmin && x <= m_xmax);
  endfunction

  task automatic drive(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic hs, input logic vs, input logic de,
                       input int x, input int y);
    vid_t e;
    bit   paint;
    @(posedge clk);
    #1;
    check_video();
    in_r = r; in_g = g; in_b = b;
    in_hs = hs; in_vs = vs; in_de = de;
    paint = ovl_en && (m_valid != 0) && de && perim(x, y);
    e.r  = paint ? 8'd255 : r;
    e.g  = paint ? 8'd255 : g;
    e.b  = paint ? 8'd0   : b;
    e.hs = hs;
    e.vs = vs;
    e.de = de;
    q.push_back(e);
  endtask

  task automatic lines(input row_t rw, input int nlines);
    bit in_blk;
    for (int y = 0; y < nlines; y++) begin
      for (int x = 0; x < rw.w; x++) begin
        in_blk = (rw.bs > 0) && x >= rw.bx && x < rw.bx + rw.bs &&
                 y >= rw.by && y < rw.by + rw.bs;
        if (in_blk)
          drive(8'(rw.br), 8'(rw.bg), 8'(rw.bb), 1'b0, 1'b0, 1'b1, x, y);
        else
          drive(8'd80, 8'd80, 8'd80, 1'b0, 1'b0, 1'b1, x, y);
      end
      for (int k = 0; k < 4; k++)
        drive(8'd0, 8'd0, 8'd0, (k == 1 || k == 2), 1'b0, 1'b0, -1, -1);
    end
  endtask

  task automatic run_row(input int idx);
    row_t rw;
    int   yel0;
    rw = tbl[idx];
    ctrl_in = 2'(rw.ctrl);
    ovl_en  = (rw.ovl != 0);
    yel0 = yel;
    lines(rw, rw.h);
    for (int k = 0; k < 4; k++) drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, -1, -1);
    for (int k = 0; k < 4; k++) drive(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, -1, -1);
    $display("frame %0d committed: valid=%0d cnt=%0d box=%0d/%0d/%0d/%0d", idx,
             box_valid, hit_count, box_xmin, box_xmax, box_ymin, box_ymax);
    chk($sformatf("f%0d_valid", idx), longint'(box_valid), longint'(rw.e_valid));
    chk($sformatf("f%0d_count", idx), longint'(hit_count), longint'(rw.e_cnt));
    chk($sformatf("f%0d_xmin", idx),  longint'(box_xmin),  longint'(rw.e_xmin));
    chk($sformatf("f%0d_xmax", idx),  longint'(box_xmax),  longint'(rw.e_xmax));
    chk($sformatf("f%0d_ymin", idx),  longint'(box_ymin),  longint'(rw.e_ymin));
    chk($sformatf("f%0d_ymax", idx),  longint'(box_ymax),  longint'(rw.e_ymax));
    chk($sformatf("f%0d_outline_px", idx), longint'(yel - yel0), longint'(rw.e_yel));
    m_valid = rw.e_valid;
    m_xmin  = rw.e_xmin;
    m_xmax  = rw.e_xmax;
    m_ymin  = rw.e_ymin;
    m_ymax  = rw.e_ymax;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_out_r"}, longint'(out_r), 0);
    chk({tag, "_out_g"}, longint'(out_g), 0);
    chk({tag, "_out_b"}, longint'(out_b), 0);
    chk({tag, "_sync"}, longint'({out_hs, out_vs, out_de}), 0);
    chk({tag, "_valid"}, longint'(box_valid), 0);
    chk({tag, "_box"}, longint'({box_xmin, box_xmax, box_ymin, box_ymax}), 0);
    chk({tag, "_count"}, longint'(hit_count), 0);
  endtask

  initial begin
    //          w    h   bx  by  bs  br  bg  bb ctrl ovl  val cnt  x0  x1  y0  y1 yel
    tbl[0] = '{ 16,   8,  0,  0,  0, 80, 80, 80, 0, 0,   0,   0,  0,  0,  0,  0,  0};
    tbl[1] = '{ 16,   8,  0,  0,  0, 80, 80, 80, 0, 0,   0,   0,  0,  0,  0,  0,  0};
    tbl[2] = '{ 16,   8,  0,  0,  0, 80, 80, 80, 1, 0,   0,   0,  0,  0,  0,  0,  0};
    tbl[3] = '{112,  62,100, 50, 10,255,  0,  0, 1, 0,   1, 100,100,109, 50, 59,  0};
    tbl[4] = '{112,  62,100, 50, 10,255,  0,  0, 1, 1,   1, 100,100,109, 50, 59, 36};
    tbl[5] = '{ 24,  16, 10,  5,  5,255,  0,  0, 3, 1,   0,  25,100,109, 50, 59,  0};
    tbl[6] = '{112,  62, 90, 42, 20,  0,  0,255, 1, 1,   0,   0,100,109, 50, 59,  0};
    tbl[7] = '{ 16,  12,  0,  0, 10,  0,255,  0, 1, 1,   1, 100,  0,  9,  0,  9,  0};
    tbl[8] = '{ 16,  12,  0,  0, 10,  0,255,  0, 1, 0,   0,   0,  0,  0,  0,  0,  0};
    tbl[9] = '{ 16,  12,  0,  0, 10,  0,255,  0, 1, 0,   1, 100,  0,  9,  0,  9,  0};

    in_r = '0; in_g = '0; in_b = '0;
    in_hs = 1'b0; in_vs = 1'b0; in_de = 1'b0;
    ctrl_in = 2'b00; ovl_en = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b1;

    for (int i = 0; i < 8; i++)
      run_row(i);

    // Reset in the middle of a frame while a valid box is being drawn
    ctrl_in = 2'b01;
    ovl_en  = 1'b1;
    lines(tbl[7], 3);
    chk("pre_reset_valid", longint'(box_valid), 1);
    #2 rst = 1'b0;
    #1;
    chk_all_zero("midframe_reset");
    in_de = 1'b0; in_vs = 1'b0; in_hs = 1'b0;
    q.delete();
    m_valid = 0; m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0;
    @(posedge clk);
    #1 rst = 1'b1;

    run_row(8);
    run_row(9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
